// File: rtl/if_stage.sv
`timescale 1ns/1ps
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC and the imem request/ack handshake. It presents one
// instruction per cycle to ID, handles branch redirects (one delay slot)
// and exception flushes, and holds its output under ID stall through a
// one-entry skid buffer.
//
// state | meaning
// IDLE  | first cycle after reset, no request issued yet
// FETCH | request at pc outstanding, waiting for ack
// HOLD  | an acked word is parked in the skid buffer while ID stalls
// DROP  | flushed while a request was outstanding; wait for its ack, discard it
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_branch_flag,
    input  logic [31:0] i_branch_target,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_inst,
    output logic        o_id_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_inst;
    logic        r_skid_valid;
    logic        r_redir_pending;
    logic [31:0] r_redir_pc;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_id_pc_nxt;
    logic [31:0] w_id_inst_nxt;
    logic        w_id_valid_nxt;
    logic [31:0] w_skid_pc_nxt;
    logic [31:0] w_skid_inst_nxt;
    logic        w_skid_valid_nxt;
    logic        w_redir_pending_nxt;
    logic [31:0] w_redir_pc_nxt;

    logic        w_req;
    logic        w_req_wait;
    logic        w_out_free;
    logic        w_consume;
    logic        w_branch;
    logic        w_ack_fetch;
    logic [31:0] w_br_tgt;
    logic [31:0] w_flush_tgt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_fetch_next;

    assign w_req       = (r_state == FETCH) || (r_state == DROP);
    assign w_req_wait  = w_req && !i_imem_ack;
    assign w_out_free  = !r_id_valid || !i_stall;
    assign w_consume   = r_id_valid && !i_stall;
    // ID's branch decision only counts in the cycle its instruction leaves id_*.
    assign w_branch    = w_consume && i_branch_flag;
    assign w_ack_fetch = (r_state == FETCH) && i_imem_ack;
    assign w_br_tgt    = i_branch_target & 32'hFFFF_FFFC;
    assign w_flush_tgt = i_flush_pc & 32'hFFFF_FFFC;
    assign w_pc_plus4  = r_pc + 32'd4;

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_id_pc     = r_id_pc;
    assign o_id_inst   = r_id_inst;
    assign o_id_valid  = r_id_valid;

    // Address of the fetch following an acked word: the acked word is the
    // delay slot when a branch is taken now or was recorded earlier.
    always_comb begin
        w_fetch_next = w_pc_plus4;
        if (w_branch) begin
            w_fetch_next = w_br_tgt;
        end else if (r_redir_pending) begin
            w_fetch_next = r_redir_pc;
        end
    end

    // Next-state logic; a flush overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (i_imem_ack && !w_out_free) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!i_stall) begin
                    w_state_nxt = FETCH;
                end
            end
            DROP: begin
                if (i_imem_ack) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (i_flush) begin
            // An unacked request must be seen through before restarting.
            w_state_nxt = w_req_wait ? DROP : FETCH;
        end
    end

    // Next values of pc, the ID output register, the skid buffer and the redirect.
    always_comb begin
        w_pc_nxt            = r_pc;
        w_id_pc_nxt         = r_id_pc;
        w_id_inst_nxt       = r_id_inst;
        w_id_valid_nxt      = r_id_valid;
        w_skid_pc_nxt       = r_skid_pc;
        w_skid_inst_nxt     = r_skid_inst;
        w_skid_valid_nxt    = r_skid_valid;
        w_redir_pending_nxt = r_redir_pending;
        w_redir_pc_nxt      = r_redir_pc;

        if (w_consume) begin
            w_id_valid_nxt = 1'b0;
        end

        // Branch taken with no word arriving now: remember the target so it
        // is applied after the delay slot has been fetched.
        if (w_branch && !w_ack_fetch) begin
            w_redir_pending_nxt = 1'b1;
            w_redir_pc_nxt      = w_br_tgt;
        end

        case (r_state)
            FETCH: begin
                if (i_imem_ack) begin
                    w_pc_nxt            = w_fetch_next;
                    w_redir_pending_nxt = 1'b0;
                    if (w_out_free) begin
                        w_id_pc_nxt    = r_pc;
                        w_id_inst_nxt  = i_imem_rdata;
                        w_id_valid_nxt = 1'b1;
                    end else begin
                        w_skid_pc_nxt    = r_pc;
                        w_skid_inst_nxt  = i_imem_rdata;
                        w_skid_valid_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!i_stall) begin
                    w_id_pc_nxt      = r_skid_pc;
                    w_id_inst_nxt    = r_skid_inst;
                    w_id_valid_nxt   = r_skid_valid;
                    w_skid_valid_nxt = 1'b0;
                end
            end
            DROP: begin
                if (i_imem_ack) begin
                    w_pc_nxt = r_redir_pc;
                end
            end
            default: begin
            end
        endcase

        if (i_flush) begin
            w_id_valid_nxt      = 1'b0;
            w_skid_valid_nxt    = 1'b0;
            w_redir_pending_nxt = 1'b0;
            if (w_req_wait) begin
                // pc keeps addressing the abandoned request until it is acked.
                w_redir_pc_nxt = w_flush_tgt;
            end else begin
                w_pc_nxt = w_flush_tgt;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc            <= RESET_PC;
            r_id_pc         <= 32'd0;
            r_id_inst       <= 32'd0;
            r_id_valid      <= 1'b0;
            r_skid_pc       <= 32'd0;
            r_skid_inst     <= 32'd0;
            r_skid_valid    <= 1'b0;
            r_redir_pending <= 1'b0;
            r_redir_pc      <= 32'd0;
        end else begin
            r_pc            <= w_pc_nxt;
            r_id_pc         <= w_id_pc_nxt;
            r_id_inst       <= w_id_inst_nxt;
            r_id_valid      <= w_id_valid_nxt;
            r_skid_pc       <= w_skid_pc_nxt;
            r_skid_inst     <= w_skid_inst_nxt;
            r_skid_valid    <= w_skid_valid_nxt;
            r_redir_pending <= w_redir_pending_nxt;
            r_redir_pc      <= w_redir_pc_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// tb_if_stage: directed and randomised stimulus for if_stage against an
// instruction-stream model (which PC must ID see next, with which word).
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    logic        br_en;
    logic        br_mode;
    logic [31:0] br_pc;
    logic [31:0] br_tgt;
    int          mem_lat;
    int          wait_cnt;
    logic [31:0] data_xor;

    int          n_chk;
    int          n_fail;
    int          n_pres;
    int          p0;

    logic [31:0] exp_next;
    logic        armed;
    logic [31:0] arm_tgt;
    logic        prev_rst;
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    logic        prev_valid;
    logic        prev_consume;
    logic        prev_flush;

    logic [31:0] t1_exp [5];

    always #5 clk = ~clk;

    // Memory: ack after mem_lat extra wait cycles; data is the address xor a key.
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = imem_addr ^ data_xor;
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // ID side: asserts branch for the instruction it currently holds.
    assign branch_flag   = br_en && id_valid &&
                           (br_mode ? (id_pc[5:2] == 4'd3) : (id_pc == br_pc));
    assign branch_target = br_mode ? (id_pc + 32'h0000_0105) : br_tgt;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_branch_flag   (branch_flag),
        .i_branch_target (branch_target),
        .i_flush         (flush),
        .i_flush_pc      (flush_pc),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (imem_ack),
        .i_imem_rdata    (imem_rdata),
        .o_id_pc         (id_pc),
        .o_id_inst       (id_inst),
        .o_id_valid      (id_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input logic [31:0] xr);
        tick;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; br_en = 1'b0; br_mode = 1'b0;
        mem_lat = lat; data_xor = xr;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_id_valid", id_valid, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        chk("rst_imem_req", imem_req, 32'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
    endtask

    // Model and per-cycle compare: sequence of presented instructions,
    // stability under stall, and handshake address stability.
    initial begin
        n_pres = 0;
        exp_next = RST_PC; armed = 1'b0; arm_tgt = 32'd0;
        prev_rst = 1'b1; prev_wait = 1'b0; prev_addr = 32'd0; prev_hold = 1'b0;
        prev_pc = 32'd0; prev_inst = 32'd0; prev_valid = 1'b0;
        prev_consume = 1'b0; prev_flush = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_next = RST_PC;
                armed    = 1'b0;
                prev_rst = 1'b1;
            end else begin
                if (!prev_rst && prev_wait) begin
                    chk("hs_req_held", imem_req, 32'd1);
                    chk("hs_addr_stable", imem_addr, prev_addr);
                end
                if (!prev_rst && !prev_flush && prev_hold) begin
                    chk("stall_valid_held", id_valid, 32'd1);
                    chk("stall_pc_held", id_pc, prev_pc);
                    chk("stall_inst_held", id_inst, prev_inst);
                end
                if (id_valid && (prev_rst || !prev_valid || prev_consume)) begin
                    n_pres++;
                    chk("seq_pc", id_pc, exp_next);
                    chk("seq_inst", id_inst, exp_next ^ data_xor);
                    if (armed) begin
                        exp_next = arm_tgt;
                        armed    = 1'b0;
                    end else begin
                        exp_next = exp_next + 32'd4;
                    end
                end
                if (flush) begin
                    exp_next = flush_pc & 32'hFFFF_FFFC;
                    armed    = 1'b0;
                end else if (id_valid && !stall && branch_flag) begin
                    armed   = 1'b1;
                    arm_tgt = branch_target & 32'hFFFF_FFFC;
                end
                prev_rst = 1'b0;
            end
            prev_wait    = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            prev_hold    = id_valid && stall;
            prev_pc      = id_pc;
            prev_inst    = id_inst;
            prev_valid   = id_valid;
            prev_consume = id_valid && !stall;
            prev_flush   = flush;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = 32'd0;
        br_en = 1'b0; br_mode = 1'b0; br_pc = 32'd0; br_tgt = 32'd0;
        mem_lat = 0; data_xor = 32'd0;
        t1_exp = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'h80000000, 32'h80000004};

        // Zero-wait, addr-as-data, branch on BFC00004 acked in the same cycle.
        do_reset(0, 32'd0);
        br_en = 1'b1; br_pc = 32'hBFC00004; br_tgt = 32'h80000000;
        tick; @(negedge clk);
        chk("t1_req_c1", imem_req, 32'd1);
        chk("t1_addr_c1", imem_addr, RST_PC);
        chk("t1_valid_c1", id_valid, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick; @(negedge clk);
            chk("t1_valid", id_valid, 32'd1);
            chk("t1_pc", id_pc, t1_exp[i]);
            chk("t1_inst", id_inst, t1_exp[i]);
        end

        // 3-cycle memory, branch sampled during the wait on the delay slot fetch.
        do_reset(2, 32'h12345678);
        br_en = 1'b1; br_pc = RST_PC; br_tgt = 32'h80001002;
        repeat (3) begin
            tick; @(negedge clk);
            chk("t3_req_first", imem_req, 32'd1);
            chk("t3_addr_first", imem_addr, RST_PC);
        end
        tick; @(negedge clk);
        chk("t3_pc_c4", id_pc, RST_PC);
        chk("t3_addr_c4", imem_addr, 32'hBFC00004);
        repeat (2) begin
            tick; @(negedge clk);
            chk("t3_addr_wait", imem_addr, 32'hBFC00004);
            chk("t3_valid_wait", id_valid, 32'd0);
        end
        tick; @(negedge clk);
        chk("t3_addr_target", imem_addr, 32'h80001000);
        chk("t3_delay_slot_pc", id_pc, 32'hBFC00004);
        chk("t3_delay_slot_inst", id_inst, 32'hBFC00004 ^ 32'h12345678);
        repeat (3) tick;
        @(negedge clk);
        chk("t3_target_pc", id_pc, 32'h80001000);

        // Stall held 4 cycles while a word is acked into the skid buffer.
        do_reset(0, 32'h0F0F0000);
        tick; tick;
        tick; stall = 1'b1; @(negedge clk);
        chk("t4_pc_c3", id_pc, 32'hBFC00004);
        repeat (3) begin
            tick; @(negedge clk);
            chk("t4_hold_req", imem_req, 32'd0);
            chk("t4_hold_pc", id_pc, 32'hBFC00004);
        end
        tick; stall = 1'b0; @(negedge clk);
        chk("t4_unstall_pc", id_pc, 32'hBFC00004);
        tick; @(negedge clk);
        chk("t4_skid_pc", id_pc, 32'hBFC00008);
        chk("t4_skid_inst", id_inst, 32'hBFC00008 ^ 32'h0F0F0000);
        chk("t4_refetch_addr", imem_addr, 32'hBFC0000C);
        tick; @(negedge clk);
        chk("t4_next_pc", id_pc, 32'hBFC0000C);

        // Reset asserted while in HOLD, then restart from RESET_PC.
        tick; tick; stall = 1'b1;
        tick; @(negedge clk);
        chk("t6_hold_req", imem_req, 32'd0);
        do_reset(0, 32'd0);
        tick; tick; @(negedge clk);
        chk("t6_restart_pc", id_pc, RST_PC);
        chk("t6_restart_valid", id_valid, 32'd1);

        // Flush during an outstanding 3-cycle request.
        do_reset(2, 32'h5555AAAA);
        tick;
        tick; flush = 1'b1; flush_pc = 32'h80000180; @(negedge clk);
        chk("t5_addr_flush", imem_addr, RST_PC);
        tick; flush = 1'b0; @(negedge clk);
        chk("t5_drop_req", imem_req, 32'd1);
        chk("t5_drop_addr", imem_addr, RST_PC);
        chk("t5_drop_valid", id_valid, 32'd0);
        tick; @(negedge clk);
        chk("t5_new_addr", imem_addr, 32'h80000180);
        chk("t5_new_valid", id_valid, 32'd0);
        tick; tick; @(negedge clk);
        chk("t5_discarded", id_valid, 32'd0);
        tick; @(negedge clk);
        chk("t5_first_pc", id_pc, 32'h80000180);
        chk("t5_first_inst", id_inst, 32'h80000180 ^ 32'h5555AAAA);

        // Flush in the same cycle as a branch: the branch is ignored.
        do_reset(0, 32'd0);
        br_en = 1'b1; br_pc = 32'hBFC00004; br_tgt = 32'h80000000;
        tick; tick;
        tick; flush = 1'b1; flush_pc = 32'h80000180; @(negedge clk);
        chk("t7_branch_pc", id_pc, 32'hBFC00004);
        tick; flush = 1'b0; @(negedge clk);
        chk("t7_valid", id_valid, 32'd0);
        chk("t7_addr", imem_addr, 32'h80000180);
        tick; @(negedge clk);
        chk("t7_pc0", id_pc, 32'h80000180);
        tick; @(negedge clk);
        chk("t7_pc1", id_pc, 32'h80000184);

        // Wrap of the fetch address past FFFFFFFC.
        do_reset(0, 32'h0000FFFF);
        tick;
        tick; flush = 1'b1; flush_pc = 32'hFFFFFFFE;
        tick; flush = 1'b0; @(negedge clk);
        chk("t8_addr_top", imem_addr, 32'hFFFFFFFC);
        chk("t8_valid", id_valid, 32'd0);
        tick; @(negedge clk);
        chk("t8_addr_wrap", imem_addr, 32'h00000000);
        chk("t8_pc_top", id_pc, 32'hFFFFFFFC);
        tick; @(negedge clk);
        chk("t8_pc_wrap", id_pc, 32'h00000000);
        chk("t8_addr_after", imem_addr, 32'h00000004);

        // Random stall and flush, 1 wait cycle, no branches.
        do_reset(1, 32'hC3C30F0F);
        p0 = n_pres;
        repeat (400) begin
            tick;
            stall    = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            flush_pc = $urandom;
        end
        tick; stall = 1'b0; flush = 1'b0;
        chk("rnd_a_progress", (n_pres - p0 >= 50), 32'd1);

        // Repeating branches with flushes, 2 wait cycles and zero wait.
        for (int lat = 2; lat >= 0; lat -= 2) begin
            do_reset(lat, 32'h9E3779B9);
            br_en = 1'b1; br_mode = 1'b1;
            p0 = n_pres;
            repeat (300) begin
                tick;
                flush    = ($urandom_range(0, 59) == 0);
                flush_pc = $urandom;
            end
            tick; flush = 1'b0;
            chk("rnd_b_progress", (n_pres - p0 >= 50), 32'd1);
        end

        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
